// File: rtl/alu_share_pkg.sv
// Shared constants and types for the time-shared ALU controller and its datapath.
package alu_share_pkg;

    localparam int unsigned DEF_W_IN  = 16;
    localparam int unsigned DEF_W_OUT = 32;
    localparam int unsigned OP_W      = 2;
    localparam int unsigned CNT_W     = 4;

    localparam logic [OP_W-1:0] OP_ADD = 2'd0;
    localparam logic [OP_W-1:0] OP_SUB = 2'd1;
    localparam logic [OP_W-1:0] OP_MUL = 2'd2;
    localparam logic [OP_W-1:0] OP_AND = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational shared ALU: operands are zero-extended to the result width before the op.
module alu_core
    import alu_share_pkg::*;
#(
    parameter int unsigned W_IN  = DEF_W_IN,
    parameter int unsigned W_OUT = DEF_W_OUT
) (
    input  logic [OP_W-1:0]  op,
    input  logic [W_IN-1:0]  a,
    input  logic [W_IN-1:0]  b,
    output logic [W_OUT-1:0] result_c
);

    logic [W_OUT-1:0] a_ext;
    logic [W_OUT-1:0] b_ext;

    assign a_ext = W_OUT'(a);
    assign b_ext = W_OUT'(b);

    // W_OUT >= 2*W_IN, so the product and the SUB wrap both fit exactly.
    always_comb begin
        result_c = '0;
        case (op)
            OP_ADD:  result_c = a_ext + b_ext;
            OP_SUB:  result_c = a_ext - b_ext;
            OP_MUL:  result_c = a_ext * b_ext;
            OP_AND:  result_c = a_ext & b_ext;
            default: result_c = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin controller time-sharing one ALU between two requesters with a
// multi-cycle execute phase and a held, backpressured response.
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned W_IN    = DEF_W_IN,
    parameter int unsigned W_OUT   = DEF_W_OUT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_req0_valid,
    output logic             io_req0_ready,
    input  logic [OP_W-1:0]  io_req0_op,
    input  logic [W_IN-1:0]  io_req0_A,
    input  logic [W_IN-1:0]  io_req0_B,
    input  logic             io_req1_valid,
    output logic             io_req1_ready,
    input  logic [OP_W-1:0]  io_req1_op,
    input  logic [W_IN-1:0]  io_req1_A,
    input  logic [W_IN-1:0]  io_req1_B,
    output logic             io_resp0_valid,
    input  logic             io_resp0_ready,
    output logic [W_OUT-1:0] io_resp0_W,
    output logic             io_resp1_valid,
    input  logic             io_resp1_ready,
    output logic [W_OUT-1:0] io_resp1_W,
    output logic             io_busy
);

    state_t            state_q;
    state_t            state_d;
    logic              ptr_q;
    logic              tag_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [OP_W-1:0]   op_q;
    logic [W_IN-1:0]   a_q;
    logic [W_IN-1:0]   b_q;
    logic [W_OUT-1:0]  res_q;
    logic [W_OUT-1:0]  alu_res_c;
    logic              gnt_c;
    logic              hs_c;

    alu_core #(
        .W_IN  (W_IN),
        .W_OUT (W_OUT)
    ) u_alu_core (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .result_c (alu_res_c)
    );

    always_ff @(posedge clock) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Grant: the lone valid requester, or the pointer's requester when both are valid.
    always_comb begin
        state_d        = state_q;
        gnt_c          = io_req1_valid && (!io_req0_valid || ptr_q);
        hs_c           = 1'b0;
        io_req0_ready  = 1'b0;
        io_req1_ready  = 1'b0;
        io_resp0_valid = 1'b0;
        io_resp1_valid = 1'b0;
        case (state_q)
            IDLE: begin
                hs_c          = io_req0_valid || io_req1_valid;
                io_req0_ready = hs_c && !gnt_c;
                io_req1_ready = hs_c && gnt_c;
                if (hs_c) state_d = EXEC;
            end
            EXEC: begin
                if (cnt_q == '0) state_d = RESP;
            end
            RESP: begin
                io_resp0_valid = !tag_q;
                io_resp1_valid = tag_q;
                if (tag_q ? io_resp1_ready : io_resp0_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture at handshake, execute countdown, result capture on the last EXEC cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr_q <= 1'b0;
            tag_q <= 1'b0;
            cnt_q <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
        end else if (hs_c) begin
            ptr_q <= !gnt_c;
            tag_q <= gnt_c;
            cnt_q <= CNT_W'(LATENCY - 1);
            op_q  <= gnt_c ? io_req1_op : io_req0_op;
            a_q   <= gnt_c ? io_req1_A  : io_req0_A;
            b_q   <= gnt_c ? io_req1_B  : io_req0_B;
        end else if (state_q == EXEC) begin
            if (cnt_q == '0) res_q <= alu_res_c;
            else             cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign io_resp0_W = tag_q ? '0 : res_q;
    assign io_resp1_W = tag_q ? res_q : '0;
    assign io_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: expected responses are queued at each request handshake.
module tb_alu_share_ctrl;
    import alu_share_pkg::*;

    localparam int unsigned LAT = 2;
    localparam int unsigned WI  = 16;
    localparam int unsigned WO  = 32;

    typedef struct packed {
        logic          tag;
        logic [WO-1:0] w;
        logic [31:0]   due;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          io_req0_valid = 1'b0, io_req1_valid = 1'b0;
    logic          io_req0_ready, io_req1_ready;
    logic [1:0]    io_req0_op = '0, io_req1_op = '0;
    logic [WI-1:0] io_req0_A = '0, io_req0_B = '0, io_req1_A = '0, io_req1_B = '0;
    logic          io_resp0_valid, io_resp1_valid;
    logic          io_resp0_ready = 1'b0, io_resp1_ready = 1'b0;
    logic [WO-1:0] io_resp0_W, io_resp1_W;
    logic          io_busy;

    exp_t        sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;
    logic        exp_ptr = 1'b0;

    alu_share_ctrl #(.LATENCY(LAT), .W_IN(WI), .W_OUT(WO)) dut (
        .clock          (clock),
        .reset          (reset),
        .io_req0_valid  (io_req0_valid),
        .io_req0_ready  (io_req0_ready),
        .io_req0_op     (io_req0_op),
        .io_req0_A      (io_req0_A),
        .io_req0_B      (io_req0_B),
        .io_req1_valid  (io_req1_valid),
        .io_req1_ready  (io_req1_ready),
        .io_req1_op     (io_req1_op),
        .io_req1_A      (io_req1_A),
        .io_req1_B      (io_req1_B),
        .io_resp0_valid (io_resp0_valid),
        .io_resp0_ready (io_resp0_ready),
        .io_resp0_W     (io_resp0_W),
        .io_resp1_valid (io_resp1_valid),
        .io_resp1_ready (io_resp1_ready),
        .io_resp1_W     (io_resp1_W),
        .io_busy        (io_busy)
    );

    always #5 clock = ~clock;

    function automatic logic [WO-1:0] model(input logic [1:0] op, input logic [WI-1:0] a,
                                            input logic [WI-1:0] b);
        logic [WO-1:0] ae;
        logic [WO-1:0] be;
        ae = {{(WO-WI){1'b0}}, a};
        be = {{(WO-WI){1'b0}}, b};
        case (op)
            2'd0:    return ae + be;
            2'd1:    return ae - be;
            2'd2:    return ae * be;
            default: return ae & be;
        endcase
    endfunction

    // Advance one clock; caller drives inputs now, then waits #1 before sampling.
    task automatic step();
        @(posedge clock);
        cyc++;
        #1;
    endtask

    // Steps until the tagged response is valid; notes any response on the other channel.
    task automatic await_valid(input logic tag, input int unsigned max_cyc,
                               output bit seen, output bit other);
        seen  = 1'b0;
        other = 1'b0;
        for (int i = 0; i < int'(max_cyc); i++) begin
            if (tag ? io_resp1_valid : io_resp0_valid) begin
                seen = 1'b1;
                break;
            end
            if (tag ? io_resp0_valid : io_resp1_valid) other = 1'b1;
            step();
            #1;
        end
    endtask

    task automatic push_exp(input logic tag, input logic [WO-1:0] w);
        exp_t e;
        e.tag = tag;
        e.w   = w;
        e.due = cyc + LAT + 1;
        sb.push_back(e);
        exp_ptr = !tag;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        #1;
        checks++;
        if (io_busy !== 1'b0 || io_resp0_valid !== 1'b0 || io_resp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: busy=%b v0=%b v1=%b, required 0 0 0",
                     io_busy, io_resp0_valid, io_resp1_valid);
        end
        reset = 1'b1;
        step();
        #1;
        exp_ptr = 1'b0;
        checks++;
        if (io_busy !== 1'b0 || io_resp0_valid !== 1'b0 || io_resp1_valid !== 1'b0 ||
            io_resp0_W !== 32'h0 || io_resp1_W !== 32'h0 ||
            io_req0_ready !== 1'b0 || io_req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b v=%b%b W0=%h W1=%h rdy=%b%b, required all 0",
                     io_busy, io_resp1_valid, io_resp0_valid, io_resp0_W, io_resp1_W,
                     io_req1_ready, io_req0_ready);
        end
    endtask

    task automatic test_single_add();
        exp_t e;
        bit   seen, other;
        io_resp0_ready = 1'b1;
        io_resp1_ready = 1'b1;
        io_req0_op = OP_ADD; io_req0_A = 16'hFFFF; io_req0_B = 16'h0001;
        io_req0_valid = 1'b1;
        #1;
        checks++;
        if (io_req0_ready !== 1'b1 || io_req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL add_grant: rdy0=%b rdy1=%b, required 1 0", io_req0_ready, io_req1_ready);
        end
        push_exp(1'b0, 32'h0001_0000);
        step();
        io_req0_valid = 1'b0;
        #1;
        checks++;
        if (io_busy !== 1'b1 || io_req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL add_exec: busy=%b rdy0=%b, required 1 0", io_busy, io_req0_ready);
        end
        await_valid(1'b0, 20, seen, other);
        e = sb.pop_front();
        checks++;
        if (!seen || other || io_resp1_valid !== 1'b0 || io_resp0_W !== e.w || cyc !== e.due) begin
            errors++;
            $display("FAIL add_resp: seen=%b other=%b W=%h cyc=%0d, required seen W=%h cyc=%0d",
                     seen, other, io_resp0_W, cyc, e.w, e.due);
        end
        step();
        #1;
        checks++;
        if (io_busy !== 1'b0 || io_resp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_done: busy=%b v0=%b, required 0 0", io_busy, io_resp0_valid);
        end
    endtask

    task automatic test_fairness();
        exp_t        e;
        int unsigned grants = 0;
        int unsigned resps  = 0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        exp_ptr = 1'b0;
        io_req0_op = OP_MUL; io_req0_A = 16'hFFFF; io_req0_B = 16'hFFFF;
        io_req1_op = OP_AND; io_req1_A = 16'hF0F0; io_req1_B = 16'h0FF0;
        io_req0_valid = 1'b1;
        io_req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 60 && resps < 4; i++) begin
            if (grants < 4 && (io_req0_ready || io_req1_ready)) begin
                checks++;
                if (io_req1_ready !== exp_ptr || io_req0_ready !== !exp_ptr) begin
                    errors++;
                    $display("FAIL fair_grant%0d: rdy0=%b rdy1=%b, required grant to %0d",
                             grants, io_req0_ready, io_req1_ready, exp_ptr);
                end
                push_exp(exp_ptr, exp_ptr ? 32'h0000_00F0 : 32'hFFFE_0001);
                grants++;
            end
            if ((io_resp0_valid || io_resp1_valid) && sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({io_resp1_valid, io_resp0_valid} !== (e.tag ? 2'b10 : 2'b01) ||
                    (e.tag ? io_resp1_W : io_resp0_W) !== e.w || cyc !== e.due) begin
                    errors++;
                    $display("FAIL fair_resp%0d: v=%b%b W0=%h W1=%h cyc=%0d, required tag=%0d W=%h cyc=%0d",
                             resps, io_resp1_valid, io_resp0_valid, io_resp0_W, io_resp1_W, cyc,
                             e.tag, e.w, e.due);
                end
                resps++;
            end
            step();
            if (grants >= 4) begin
                io_req0_valid = 1'b0;
                io_req1_valid = 1'b0;
            end
            #1;
        end
        checks++;
        if (resps != 4 || sb.size() != 0) begin
            errors++;
            $display("FAIL fair_count: responses=%0d pending=%0d, required 4 0", resps, sb.size());
        end
    endtask

    task automatic test_backpressure();
        exp_t        e;
        bit          seen, other;
        int unsigned rise;
        io_resp1_ready = 1'b0;
        io_req1_op = OP_SUB; io_req1_A = 16'h0001; io_req1_B = 16'h0002;
        io_req1_valid = 1'b1;
        #1;
        checks++;
        if (io_req1_ready !== 1'b1 || io_req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_grant: rdy0=%b rdy1=%b, required 0 1", io_req0_ready, io_req1_ready);
        end
        push_exp(1'b1, 32'hFFFF_FFFF);
        step();
        io_req1_valid = 1'b0;
        io_req0_op = OP_ADD; io_req0_A = 16'd3; io_req0_B = 16'd4;
        io_req0_valid = 1'b1;
        #1;
        await_valid(1'b1, 20, seen, other);
        e = sb.pop_front();
        checks++;
        if (!seen || other || io_resp1_W !== e.w || cyc !== e.due) begin
            errors++;
            $display("FAIL bp_resp: seen=%b other=%b W=%h cyc=%0d, required W=%h cyc=%0d",
                     seen, other, io_resp1_W, cyc, e.w, e.due);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (io_resp1_valid !== 1'b1 || io_resp1_W !== 32'hFFFF_FFFF || io_resp0_valid !== 1'b0 ||
                io_req0_ready !== 1'b0 || io_req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: v1=%b W1=%h v0=%b rdy=%b%b, required 1 ffffffff 0 00",
                         i, io_resp1_valid, io_resp1_W, io_resp0_valid, io_req1_ready, io_req0_ready);
            end
            step();
            #1;
        end
        io_resp1_ready = 1'b1;
        #1;
        rise = cyc;
        checks++;
        if (io_resp1_valid !== 1'b1 || io_req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: v1=%b rdy0=%b, required 1 0", io_resp1_valid, io_req0_ready);
        end
        step();
        #1;
        checks++;
        if (io_req0_ready !== 1'b1 || io_busy !== 1'b0 || io_resp1_valid !== 1'b0 || cyc !== rise + 1) begin
            errors++;
            $display("FAIL bp_next_grant: rdy0=%b busy=%b v1=%b cyc=%0d, required 1 0 0 cyc=%0d",
                     io_req0_ready, io_busy, io_resp1_valid, cyc, rise + 1);
        end
        push_exp(1'b0, 32'd7);
        step();
        io_req0_valid = 1'b0;
        #1;
        await_valid(1'b0, 20, seen, other);
        e = sb.pop_front();
        checks++;
        if (!seen || other || io_resp0_W !== e.w || cyc !== e.due) begin
            errors++;
            $display("FAIL bp_followup: seen=%b W=%h cyc=%0d, required W=%h cyc=%0d",
                     seen, io_resp0_W, cyc, e.w, e.due);
        end
        step();
        #1;
    endtask

    task automatic test_reset_mid_op();
        exp_t e;
        bit   seen, other;
        bit   pulse = 1'b0;
        io_req0_op = OP_ADD; io_req0_A = 16'd3; io_req0_B = 16'd4;
        io_req0_valid = 1'b1;
        #1;
        step();
        io_req0_valid = 1'b0;
        #1;
        reset = 1'b0;
        step();
        reset = 1'b1;
        #1;
        exp_ptr = 1'b0;
        checks++;
        if (io_busy !== 1'b0 || io_resp0_valid !== 1'b0 || io_resp1_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle: busy=%b v=%b%b, required 0 00",
                     io_busy, io_resp1_valid, io_resp0_valid);
        end
        for (int i = 0; i < 5; i++) begin
            if (io_resp0_valid || io_resp1_valid || io_busy) pulse = 1'b1;
            step();
            #1;
        end
        checks++;
        if (pulse) begin
            errors++;
            $display("FAIL rst_mid_quiet: activity after reset=1, required none");
        end
        io_req1_op = OP_AND; io_req1_A = 16'hFFFF; io_req1_B = 16'hFFFF;
        io_req0_valid = 1'b1;
        io_req1_valid = 1'b1;
        #1;
        checks++;
        if (io_req0_ready !== 1'b1 || io_req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ptr: rdy0=%b rdy1=%b, required 1 0", io_req0_ready, io_req1_ready);
        end
        push_exp(1'b0, 32'd7);
        step();
        io_req0_valid = 1'b0;
        io_req1_valid = 1'b0;
        #1;
        await_valid(1'b0, 20, seen, other);
        e = sb.pop_front();
        checks++;
        if (!seen || other || io_resp0_W !== e.w || cyc !== e.due) begin
            errors++;
            $display("FAIL rst_mid_add: seen=%b W=%h cyc=%0d, required W=%h cyc=%0d",
                     seen, io_resp0_W, cyc, e.w, e.due);
        end
        step();
        #1;
    endtask

    task automatic test_operand_stability();
        exp_t e;
        bit   seen, other;
        io_req0_op = OP_ADD; io_req0_A = 16'h0005; io_req0_B = 16'h0005;
        io_req0_valid = 1'b1;
        #1;
        push_exp(1'b0, 32'h0000_000A);
        step();
        io_req0_A = 16'h1234;
        io_req0_valid = 1'b0;
        #1;
        await_valid(1'b0, 20, seen, other);
        e = sb.pop_front();
        checks++;
        if (!seen || other || io_resp0_W !== e.w || cyc !== e.due) begin
            errors++;
            $display("FAIL operand_hold: seen=%b W=%h cyc=%0d, required W=%h cyc=%0d",
                     seen, io_resp0_W, cyc, e.w, e.due);
        end
        step();
        #1;
    endtask

    task automatic test_random_ops();
        exp_t          e;
        bit            seen, other;
        logic          tag;
        logic [1:0]    op;
        logic [WI-1:0] a, b;
        for (int n = 0; n < 8; n++) begin
            tag = 1'($urandom_range(0, 1));
            op  = 2'(n % 4);
            a   = 16'($urandom);
            b   = 16'($urandom);
            if (tag) begin
                io_req1_op = op; io_req1_A = a; io_req1_B = b; io_req1_valid = 1'b1;
            end else begin
                io_req0_op = op; io_req0_A = a; io_req0_B = b; io_req0_valid = 1'b1;
            end
            #1;
            checks++;
            if ((tag ? io_req1_ready : io_req0_ready) !== 1'b1) begin
                errors++;
                $display("FAIL rand_grant%0d: requester %0d not granted", n, tag);
            end
            push_exp(tag, model(op, a, b));
            step();
            io_req0_valid = 1'b0;
            io_req1_valid = 1'b0;
            #1;
            await_valid(tag, 20, seen, other);
            e = sb.pop_front();
            checks++;
            if (!seen || other || (tag ? io_resp1_W : io_resp0_W) !== e.w || cyc !== e.due) begin
                errors++;
                $display("FAIL rand_resp%0d: op=%0d A=%h B=%h W=%h cyc=%0d, required W=%h cyc=%0d",
                         n, op, a, b, tag ? io_resp1_W : io_resp0_W, cyc, e.w, e.due);
            end
            step();
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_fairness();
        test_backpressure();
        test_reset_mid_op();
        test_operand_stability();
        test_random_ops();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Time-shares one 16x16->32 ALU between two requesters, each with its own valid/ready request and response channels.
- Round-robin arbitration, a configurable multi-cycle execute phase, and a held response with backpressure.
- Sits between issuing front-ends and the shared ALU datapath, replacing direct wiring of operands to the adder.

Parameters:
- LATENCY, 2, execute cycles spent in EXEC before the result is presented; legal range 1..15.
- W_IN, 16, operand width.
- W_OUT, 32, result width; must be >= 2*W_IN.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising clock edge, asserted when 0.
- io_req0_valid  input  1  requester 0 has an operation.
- io_req0_ready  output  1  controller accepts requester 0 this cycle.
- io_req0_op  input  2  operation code: 0=ADD, 1=SUB, 2=MUL, 3=AND.
- io_req0_A  input  W_IN  operand A.
- io_req0_B  input  W_IN  operand B.
- io_req1_valid, io_req1_ready, io_req1_op, io_req1_A, io_req1_B: same as requester 0, for requester 1.
- io_resp0_valid  output  1  result for requester 0 is held.
- io_resp0_ready  input  1  requester 0 consumes the result.
- io_resp0_W  output  W_OUT  result for requester 0.
- io_resp1_valid, io_resp1_ready, io_resp1_W: same as response 0, for requester 1.
- io_busy  output  1  high whenever the state is not IDLE.

Behaviour:
- States: IDLE, EXEC, RESP. Reset value is IDLE.
- Reset values:
  - all *_ready and *_valid = 0 except the combinational ready in IDLE;
  - io_resp*_W = 0;
  - priority pointer = 0 (requester 0 preferred);
  - execute counter = 0.
- IDLE:
  - io_reqN_ready is high only for the granted requester, and only in IDLE.
  - Grant goes to the single valid requester. If both are valid, grant goes to the pointer's requester.
  - On handshake (valid & ready): latch op, A, B and grant tag; load counter = LATENCY-1; go to EXEC; pointer becomes the other requester.
  - With no valid requester, stay in IDLE and leave the pointer unchanged.
- EXEC:
  - Both readies are 0.
  - Counter decrements each cycle. When the counter is 0, the ALU output is registered into the result register and the state moves to RESP.
- RESP:
  - io_resp[tag]_valid = 1 and io_resp[tag]_W = result register. The other response channel holds valid=0.
  - When io_resp[tag]_ready = 1, the response completes and the state returns to IDLE. That IDLE cycle may grant a new request; there is no combinational ready bypass in RESP.
- Latency:
  - Request handshake at cycle t gives resp_valid first high at cycle t+LATENCY+1.
  - Minimum issue interval is LATENCY+2 cycles with ready held high.
- Arithmetic, all operands zero-extended to W_OUT:
  - ADD = A+B; bit 16 carries, no overflow possible.
  - SUB = (A-B) mod 2^W_OUT; A<B yields upper bits all 1s.
  - MUL = unsigned A*B, full product.
  - AND = A&B in the low W_IN bits, upper bits 0.
- Operand latching:
  - Operands are latched at the handshake; later changes to io_req* inputs do not affect the result.
  - io_resp*_W holds stable while valid is high and not yet accepted.
- Reset asserted mid-EXEC or mid-RESP:
  - Return to IDLE on that edge; the in-flight result is discarded with no response.
  - Pointer returns to 0.
- A requester deasserting valid before grant is legal; no state change results.

Decomposition:
- Shared package alu_share_pkg holds:
  - the op code constants (OP_ADD, OP_SUB, OP_MUL, OP_AND);
  - the state encoding (IDLE=0, EXEC=1, RESP=2);
  - the W_IN and W_OUT defaults.
- Sub-module alu_core: purely combinational, inputs op, A, B, output W_OUT result. The controller instantiates it once and feeds it from the latched operand registers.
- The controller owns only the FSM, arbiter pointer, counter and result/tag registers.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, then release with no requests -> io_busy=0, both resp_valid=0, both resp_W=0.
- Single add, LATENCY=2: req0 ADD A=0xFFFF B=0x0001 handshake at t -> io_resp0_valid at t+3 with W=0x00010000; io_resp1_valid stays 0.
- Arbitration fairness: both requesters valid continuously with MUL A=0xFFFF B=0xFFFF (req0) and AND A=0xF0F0 B=0x0FF0 (req1), resp readies high -> grants alternate 0,1,0,1. Results are 0xFFFE0001 and 0x000000F0.
- Backpressure: SUB A=0x0001 B=0x0002 from req1, with io_resp1_ready low for 5 cycles in RESP -> W=0xFFFFFFFF held stable, io_req*_ready=0 throughout. The first new grant comes the cycle after ready rises.
- Reset mid-operation: reset=0 during EXEC -> next cycle IDLE, no resp_valid pulse; the following req0 ADD 3+4 returns W=7 with normal latency.
- Operand stability: change io_req0_A from 0x0005 to 0x1234 the cycle after handshake of ADD 5+5 -> result 0x0000000A.
